// File: rtl/usrt_tx_ctrl.sv
// USRT transmit controller: accepts a byte over valid/ready and serialises a
// start/data/parity/stop frame on o_Tx with a companion serial clock o_SClk.
module usrt_tx_ctrl #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       i_Pclk,
  input  logic       i_Rst_n,
  input  logic [7:0] i_Data,
  input  logic [1:0] i_Parity,
  input  logic       i_Valid,
  output logic       o_Ready,
  output logic       o_Tx,
  output logic       o_SClk,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] DONE_AT = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic            bit_end;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            par_en;
  logic            par_bit;

  assign cnt_inc = cnt + 1'b1;
  assign bit_end = (cnt == LAST);

  // Every output is a register loaded with the value it must show in the
  // cycle after the edge, so each transition sets the outputs of the new bit.
  always_ff @(posedge i_Pclk) begin
    // NOTE: sequential state uses non-blocking assignments only; a later
    // assignment in the same block to the same register overrides an earlier one.
    if (!i_Rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      o_Ready <= 1'b0;
      o_Tx    <= 1'b1;
      o_SClk  <= 1'b1;
      o_Busy  <= 1'b0;
      o_Done  <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_Tx    <= 1'b1;
          o_SClk  <= 1'b1;
          o_Busy  <= 1'b0;
          cnt     <= '0;
          bit_idx <= '0;
          if (i_Valid && o_Ready) begin
            state   <= START;
            shreg   <= i_Data;
            par_en  <= (i_Parity == 2'b01) || (i_Parity == 2'b10);
            par_bit <= (^i_Data) ^ (i_Parity == 2'b10);
            o_Ready <= 1'b0;
            o_Busy  <= 1'b1;
            o_Tx    <= 1'b0;
            o_SClk  <= 1'b0;
          end else begin
            o_Ready <= 1'b1;
          end
        end

        START, DATA, PARITY, STOP: begin
          if (bit_end) begin
            cnt    <= '0;
            o_SClk <= 1'b0;
            case (state)
              START: begin
                state   <= DATA;
                bit_idx <= '0;
                o_Tx    <= shreg[0];
              end
              DATA: begin
                if (bit_idx == 3'd7) begin
                  if (par_en) begin
                    state <= PARITY;
                    o_Tx  <= par_bit;
                  end else begin
                    state <= STOP;
                    o_Tx  <= 1'b1;
                  end
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                  shreg   <= shreg >> 1;
                  o_Tx    <= shreg[1];
                end
              end
              PARITY: begin
                state <= STOP;
                o_Tx  <= 1'b1;
              end
              STOP: begin
                // Frame complete: drop back to the idle line levels.
                state   <= IDLE;
                o_Tx    <= 1'b1;
                o_SClk  <= 1'b1;
                o_Busy  <= 1'b0;
                o_Ready <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end else begin
            cnt    <= cnt_inc;
            o_SClk <= (cnt_inc >= HALF);
            if (state == STOP && cnt == DONE_AT)
              o_Done <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          o_Ready <= 1'b0;
          o_Tx    <= 1'b1;
          o_SClk  <= 1'b1;
          o_Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usrt_tx_ctrl.sv
// Self-checking bench for usrt_tx_ctrl: table of hand-computed frames plus
// directed sequences for back-to-back transfer, input toggling and mid-frame reset.
module tb_usrt_tx_ctrl;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_Data;
  logic [1:0] i_Parity;
  logic       i_Valid;
  logic       o_Ready;
  logic       o_Tx;
  logic       o_SClk;
  logic       o_Busy;
  logic       o_Done;

  int checks   = 0;
  int failures = 0;

  usrt_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .i_Pclk  (clk),
    .i_Rst_n (rst_n),
    .i_Data  (i_Data),
    .i_Parity(i_Parity),
    .i_Valid (i_Valid),
    .o_Ready (o_Ready),
    .o_Tx    (o_Tx),
    .o_SClk  (o_SClk),
    .o_Busy  (o_Busy),
    .o_Done  (o_Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame bits: bit k is the k-th bit on the line (start first).
  typedef struct {
    logic [7:0]  data;
    logic [1:0]  par;
    logic [10:0] frame;
    int          nbits;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake one byte, then watch every clock of the frame and the idle clock after it.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] p,
                           input logic [10:0] exp, input int nb,
                           input bit toggle, input bit keep_valid);
    int w;
    int cyc;
    int done_cyc;
    int tx_err, sclk_err, busy_err, rdy_err, done_err;
    logic [10:0] obs;
    w = 0;
    while (o_Ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, o_Ready, 1'b1);
    i_Data   = d;
    i_Parity = p;
    i_Valid  = 1'b1;
    @(posedge clk);
    obs = '0; cyc = 0; done_cyc = -1;
    tx_err = 0; sclk_err = 0; busy_err = 0; rdy_err = 0; done_err = 0;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        cyc++;
        if (!keep_valid) i_Valid = 1'b0;
        if (toggle) begin
          i_Data   = 8'($urandom);
          i_Parity = 2'($urandom);
        end
        if (c == 0) obs[k] = o_Tx;
        if (o_Tx !== exp[k]) tx_err++;
        if (o_SClk !== (c >= CPB / 2)) sclk_err++;
        if (o_Busy !== 1'b1) busy_err++;
        if (o_Ready !== 1'b0) rdy_err++;
        if (o_Done === 1'b1) begin
          if (done_cyc < 0) done_cyc = cyc;
          else done_err++;
        end
      end
    end
    check({tag, "_frame"}, obs, exp);
    check({tag, "_tx_stable_err"}, tx_err, 0);
    check({tag, "_sclk_err"}, sclk_err, 0);
    check({tag, "_busy_err"}, busy_err, 0);
    check({tag, "_ready_low_err"}, rdy_err, 0);
    // o_Done sits in the last clock of the frame: clock nb*CPB after the handshake edge.
    check({tag, "_done_clock"}, done_cyc, nb * CPB);
    check({tag, "_done_extra"}, done_err, 0);
    @(negedge clk);
    check({tag, "_post_ready"}, o_Ready, 1'b1);
    check({tag, "_post_busy"}, o_Busy, 1'b0);
    check({tag, "_post_done"}, o_Done, 1'b0);
    check({tag, "_post_tx"}, o_Tx, 1'b1);
    check({tag, "_post_sclk"}, o_SClk, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 2'b01, 11'b10101001010, 11};  // even, 4 ones -> parity 0
    vecs[1] = '{8'h01, 2'b10, 11'b10000000010, 11};  // odd -> parity 0
    vecs[2] = '{8'h01, 2'b01, 11'b11000000010, 11};  // even -> parity 1
    vecs[3] = '{8'hFF, 2'b00, 11'b01111111110, 10};  // no parity slot
    vecs[4] = '{8'hFF, 2'b11, 11'b01111111110, 10};  // 11 also means none
    vecs[5] = '{8'h55, 2'b10, 11'b11010101010, 11};  // odd, 4 ones -> parity 1
    vecs[6] = '{8'h00, 2'b01, 11'b10000000000, 11};  // even, zero ones -> parity 0
    vecs[7] = '{8'h80, 2'b10, 11'b10100000000, 11};  // odd, 1 one -> parity 0

    rst_n    = 1'b0;
    i_Valid  = 1'b0;
    i_Data   = 8'h00;
    i_Parity = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_tx", o_Tx, 1'b1);
    check("rst_sclk", o_SClk, 1'b1);
    check("rst_ready", o_Ready, 1'b0);
    check("rst_busy", o_Busy, 1'b0);
    check("rst_done", o_Done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", o_Ready, 1'b1);

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par,
                vecs[i].frame, vecs[i].nbits, 1'b0, 1'b0);

    // Inputs scrambled every clock of the frame: only the latched byte is sent.
    run_frame("toggle", 8'h96, 2'b10, 11'b11100101100, 11, 1'b1, 1'b0);

    // i_Valid held high across two frames; data scrambled during frame 1.
    run_frame("b2b_1", 8'h3C, 2'b01, 11'b10001111000, 11, 1'b1, 1'b1);
    run_frame("b2b_2", 8'hC3, 2'b01, 11'b10110000110, 11, 1'b0, 1'b0);

    // Abort during data bit 3 of a 0x3C frame.
    i_Data   = 8'h3C;
    i_Parity = 2'b01;
    i_Valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_Valid = 1'b0;
    repeat (16) @(negedge clk);
    check("abort_pre_tx_bit3", o_Tx, 1'b1);
    check("abort_pre_busy", o_Busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_tx", o_Tx, 1'b1);
    check("abort_sclk", o_SClk, 1'b1);
    check("abort_busy", o_Busy, 1'b0);
    check("abort_ready", o_Ready, 1'b0);
    check("abort_done", o_Done, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("abort_hold_done%0d", i), o_Done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rel_ready", o_Ready, 1'b1);
    check("abort_rel_busy", o_Busy, 1'b0);
    run_frame("after_abort", 8'h55, 2'b00, 11'b01010101010, 10, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
